// File: rtl/arbiter4x2_if.sv
// Handshake bundle for the 4-requester, single-output round-robin arbiter.
// The master modport is the arbiter's view, and the slave modport is the surrounding environment.
interface arbiter4x2_if #(
  parameter int unsigned WIDTH = 2
);
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic [WIDTH-1:0] I2;
  logic [WIDTH-1:0] I3;
  logic [3:0]       V;
  logic [3:0]       R;
  logic [WIDTH-1:0] O;
  logic             OV;
  logic             OR;
  logic [1:0]       S;

  modport master (
    input  I0, I1, I2, I3, V, OR,
    output R, O, OV, S
  );

  modport slave (
    output I0, I1, I2, I3, V, OR,
    input  R, O, OV, S
  );
endinterface

// File: rtl/arbiter4x2.sv
// Round-robin arbiter: four valid/ready requesters feed one registered output slot.
// Drain and reload at the same edge give one word per cycle.
module arbiter4x2 #(
  parameter int unsigned WIDTH = 2
) (
  input logic          CLK,
  input logic          RESET,
  arbiter4x2_if.master bus
);

  typedef enum logic {StEmpty = 1'b0, StFull = 1'b1} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] o_q;
  logic [1:0]       s_q;
  logic [1:0]       last_q;

  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic             load;
  logic             grant;
  logic [WIDTH-1:0] win_data;

  // Search starts just after the last grant; k=4 wraps back onto last_q itself.
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && bus.V[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    load     = (state_q == StEmpty) || bus.OR;
    grant    = load && found && !RESET;
    bus.R    = grant ? (4'b0001 << win) : 4'b0000;
    win_data = win[1] ? (win[0] ? bus.I3 : bus.I2) : (win[0] ? bus.I1 : bus.I0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StEmpty;
      o_q     <= '0;
      s_q     <= 2'd0;
      last_q  <= 2'd3;
    end else if (grant) begin
      state_q <= StFull;
      o_q     <= win_data;
      s_q     <= win;
      last_q  <= win;
    end else if (state_q == StFull && bus.OR) begin
      state_q <= StEmpty;
    end
  end

  assign bus.O  = o_q;
  assign bus.OV = (state_q == StFull);
  assign bus.S  = s_q;

endmodule

// File: tb/tb_arbiter4x2.sv
// Directed and randomized checks of arbiter4x2.
// A reference model and a transfer scoreboard provide the expected values.
module tb_arbiter4x2;
  localparam int unsigned W = 2;

  logic CLK;
  logic RESET;

  arbiter4x2_if #(.WIDTH(W)) bus ();

  arbiter4x2 #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int data;
    int idx;
  } ent_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t sb[$];
  bit   m_full;
  int   m_o;
  int   m_s;
  int   m_last;
  int   wait_cnt[4];
  logic [3:0] r_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // First valid index scanning last+1 .. last+4 modulo 4, or -1 when nothing is valid.
  function automatic int pick(input bit [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // One clock: drive inputs, check R and output transfers, clock, then check registered outputs.
  task automatic cycle(input bit rst, input bit [3:0] v, input bit orr,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3);
    int   w;
    bit   load;
    int   d[4];
    logic [3:0] exp_r;
    ent_t e;
    d[0] = int'(d0);
    d[1] = int'(d1);
    d[2] = int'(d2);
    d[3] = int'(d3);
    RESET  = rst;
    bus.V  = v;
    bus.OR = orr;
    bus.I0 = d0;
    bus.I1 = d1;
    bus.I2 = d2;
    bus.I3 = d3;
    #2;
    load  = !m_full || orr;
    w     = pick(v, m_last);
    exp_r = (!rst && load && w >= 0) ? 4'(1 << w) : 4'b0000;
    r_seen = bus.R;
    chk("r", 32'(bus.R), 32'(exp_r));
    chk("r_onehot0_subset_v", 32'($onehot0(bus.R) && ((bus.R & ~v) == 4'b0)), 32'd1);
    if (!rst && bus.OV && orr) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_data", 32'(bus.O), e.data);
        chk("sb_idx", 32'(bus.S), e.idx);
      end
    end
    @(posedge CLK);
    if (rst) begin
      m_full = 1'b0;
      m_o    = 0;
      m_s    = 0;
      m_last = 3;
      sb.delete();
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) if (!v[i]) wait_cnt[i] = 0;
      if (load && w >= 0) begin
        for (int i = 0; i < 4; i++) begin
          if (v[i]) begin
            if (i == w) begin
              chk("starve", 32'(wait_cnt[i] <= 3), 32'd1);
              wait_cnt[i] = 0;
            end else begin
              wait_cnt[i]++;
            end
          end
        end
        sb.push_back('{data: d[w], idx: w});
        m_o    = d[w];
        m_s    = w;
        m_last = w;
        m_full = 1'b1;
      end else if (m_full && orr) begin
        m_full = 1'b0;
      end
    end
    #1;
    chk("ov", 32'(bus.OV), 32'(m_full));
    chk("o", 32'(bus.O), m_o);
    chk("s", 32'(bus.S), m_s);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]   rr_r[5];
    bit [3:0]     rv;
    logic [W-1:0] rd[4];
    bit           rst;
    bit           orr;

    rr_r   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    m_full = 1'b0;
    m_o    = 0;
    m_s    = 0;
    m_last = 3;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    RESET  = 1'b1;
    bus.V  = 4'b0;
    bus.OR = 1'b0;
    bus.I0 = '0;
    bus.I1 = '0;
    bus.I2 = '0;
    bus.I3 = '0;

    // Reset with every requester valid must grant nothing.
    cycle(1'b1, 4'b1111, 1'b1, 2'd0, 2'd1, 2'd2, 2'd3);
    chk("rst_r", 32'(r_seen), 32'd0);
    chk("rst_ov", 32'(bus.OV), 32'd0);
    chk("rst_o", 32'(bus.O), 32'd0);
    chk("rst_s", 32'(bus.S), 32'd0);

    // Full rotation at one word per cycle.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 4'b1111, 1'b1, 2'd0, 2'd1, 2'd2, 2'd3);
      chk("rr_r", 32'(r_seen), 32'(rr_r[k]));
      chk("rr_o", 32'(bus.O), k % 4);
      chk("rr_s", 32'(bus.S), k % 4);
      chk("rr_ov", 32'(bus.OV), 32'd1);
    end
    cycle(1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
    chk("drain_ov", 32'(bus.OV), 32'd0);

    // Single requester, then downstream stall.
    cycle(1'b0, 4'b0100, 1'b0, 2'd0, 2'd0, 2'b10, 2'd0);
    chk("stall_grant_r", 32'(r_seen), 32'b0100);
    chk("stall_grant_o", 32'(bus.O), 32'b10);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 4'b0100, 1'b0, 2'd0, 2'd0, 2'b10, 2'd0);
      chk("stall_r", 32'(r_seen), 32'd0);
      chk("stall_o", 32'(bus.O), 32'b10);
      chk("stall_s", 32'(bus.S), 32'd2);
      chk("stall_ov", 32'(bus.OV), 32'd1);
    end
    cycle(1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
    chk("release_ov", 32'(bus.OV), 32'd0);
    chk("release_o_hold", 32'(bus.O), 32'b10);
    chk("release_s_hold", 32'(bus.S), 32'd2);

    // After a grant to requester 3, the pointer wraps to 0 before 2.
    cycle(1'b0, 4'b1000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd3);
    chk("g3_r", 32'(r_seen), 32'b1000);
    cycle(1'b0, 4'b0101, 1'b1, 2'd1, 2'd0, 2'd2, 2'd0);
    chk("wrap_r0", 32'(r_seen), 32'b0001);
    chk("wrap_s0", 32'(bus.S), 32'd0);
    cycle(1'b0, 4'b0101, 1'b1, 2'd1, 2'd0, 2'd2, 2'd0);
    chk("wrap_r2", 32'(r_seen), 32'b0100);
    chk("wrap_o2", 32'(bus.O), 32'd2);

    // Reset while full and stalled discards the word; priority restarts at 0.
    cycle(1'b1, 4'b1111, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    chk("midrst_r", 32'(r_seen), 32'd0);
    chk("midrst_ov", 32'(bus.OV), 32'd0);
    chk("midrst_o", 32'(bus.O), 32'd0);
    cycle(1'b0, 4'b0110, 1'b1, 2'd0, 2'd3, 2'd2, 2'd0);
    chk("post_rst_r", 32'(r_seen), 32'b0010);
    chk("post_rst_o", 32'(bus.O), 32'd3);
    chk("post_rst_s", 32'(bus.S), 32'd1);

    // Random traffic; each requester holds its word and valid until transferred.
    rv = 4'b0;
    for (int i = 0; i < 4; i++) rd[i] = '0;
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      orr = ($urandom_range(0, 3) != 0);
      cycle(rst, rv, orr, rd[0], rd[1], rd[2], rd[3]);
      for (int i = 0; i < 4; i++) begin
        if (!rv[i] || r_seen[i]) begin
          rv[i] = 1'($urandom_range(0, 1));
          rd[i] = W'($urandom);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/arbiter4x2.md
ARBITER4X2 -- requirements
Module: arbiter4x2

Interface
REQ-001: Parameter WIDTH, default 2, bit width of each requester data word and of the output word.
REQ-002: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003: RESET  input  1  synchronous, active-high reset.
REQ-004: I0, I1, I2, I3  input  WIDTH each  requester data words, index 0..3.
REQ-005: V  input  4  requester valid; V[i] qualifies Ii.
REQ-006: R  output  4  requester ready; transfer from requester i when V[i]&R[i] at a rising edge.
REQ-007: O  output  WIDTH  registered output data word.
REQ-008: OV  output  1  output valid.
REQ-009: OR  input  1  downstream ready; output transfer when OV&OR at a rising edge.
REQ-010: S  output  2  index of the requester whose word is currently held in O.

Function
REQ-011: Two states: EMPTY (OV=0) and FULL (OV=1); OV is the state bit.
REQ-012: LOAD condition = (EMPTY) or (FULL and OR=1).
REQ-013: Winner selection round-robin: search indices LAST+1, LAST+2, LAST+3, LAST+4 (mod 4), first with V set wins; LAST is a 2-bit internal last-grant pointer.
REQ-014: R = one-hot of winner when LOAD and any V set; R = 0 otherwise; R combinational from V, OV, OR, LAST.
REQ-015: At most one R bit high in any cycle; R[i] never high while V[i]=0.
REQ-016: On edge with LOAD and winner w: O <= Iw, S <= w, LAST <= w, OV <= 1.
REQ-017: On edge with FULL, OR=1 and no V set: OV <= 0; O and S hold last values.
REQ-018: On edge with FULL and OR=0: O, S, OV, LAST all hold; R=0 that cycle.
REQ-019: On edge with EMPTY and no V set: all state holds.
REQ-020: Latency: requester transfer at edge n makes word visible on O with OV=1 after edge n; simultaneous downstream drain and reload at same edge gives one word per cycle sustained throughput.
REQ-021: LAST advances only on a requester transfer, never on output-only transfers or stalls.
REQ-022: Requester with V held high while not granted is granted within 4 LOAD cycles (no starvation).
REQ-023: Requesters SHALL hold Ii and V[i] stable until transfer; arbiter output behavior undefined otherwise only in data value, never in handshake rules.
REQ-024: Winner's data muxed by S-style 2-level select over the four words, WIDTH bits, no truncation or extension.

Reset
REQ-025: RESET high at an edge: OV <= 0, O <= 0, S <= 0, LAST <= 3 (requester 0 has first priority).
REQ-026: While RESET high, R = 0 regardless of V and OR; no requester transfer occurs.
REQ-027: RESET mid-operation discards any held word (OV=0 next cycle) with no output transfer counted.
REQ-028: RESET overrides all simultaneous LOAD or drain events.

Verification
REQ-029: After reset, V=4'b1111, OR=1 constantly, I0..I3=0,1,2,3 -> R sequence 0001,0010,0100,1000,0001; O/S sequence 0,1,2,3,0 starting one cycle later, OV=1 every cycle.
REQ-030: V=4'b0100, I2=2'b10, OR=0 for 5 cycles -> R=0100 for one cycle only, then O=2'b10, S=2, OV=1 held stable 5 cycles with R=0; OR=1 -> OV=0 next cycle.
REQ-031: After grant to 3, V=4'b0101 -> winner 0 (search 0,1,2,3 from LAST+1), then next LOAD winner 2.
REQ-032: FULL with OR=1 and V=0 -> OV drops to 0 next edge, O retains value, LAST unchanged.
REQ-033: RESET asserted while FULL and OR=0 -> next cycle OV=0, O=0, S=0, R=0; first grant after release goes to lowest-index valid requester.
REQ-034: Random V/OR/data stimulus, 10k cycles -> scoreboard confirms every requester transfer appears exactly once on output in order, R one-hot-or-zero, no requester waits more than 4 LOAD cycles.
